// File: rtl/wash_pkg.sv
// Shared machine-state encodings and wash-program time words for the
// mode controller and the downstream run-timer.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } state_e;

  localparam int DATA_W = 26;

  localparam int SOAK_W   = 3;  localparam int SOAK_LSB   = 23;
  localparam int WASH_W   = 4;  localparam int WASH_LSB   = 19;
  localparam int DRAIN1_W = 3;  localparam int DRAIN1_LSB = 16;
  localparam int RINSE_W  = 3;  localparam int RINSE_LSB  = 13;
  localparam int DRAIN2_W = 3;  localparam int DRAIN2_LSB = 10;
  localparam int SPIN_W   = 4;  localparam int SPIN_LSB   = 6;
  localparam int COOL_W   = 3;  localparam int COOL_LSB   = 3;
  localparam int UNLOCK_W = 3;  localparam int UNLOCK_LSB = 0;

  // Packs per-stage times MSB first: soak, wash, drain1, rinse, drain2, spin, cool, unlock.
  function automatic logic [DATA_W-1:0] pack_prog(
    input int soak, input int wash, input int drain1, input int rinse,
    input int drain2, input int spin, input int cool, input int unlock);
    logic [DATA_W-1:0] w;
    w = '0;
    w[SOAK_LSB   +: SOAK_W]   = SOAK_W'(soak);
    w[WASH_LSB   +: WASH_W]   = WASH_W'(wash);
    w[DRAIN1_LSB +: DRAIN1_W] = DRAIN1_W'(drain1);
    w[RINSE_LSB  +: RINSE_W]  = RINSE_W'(rinse);
    w[DRAIN2_LSB +: DRAIN2_W] = DRAIN2_W'(drain2);
    w[SPIN_LSB   +: SPIN_W]   = SPIN_W'(spin);
    w[COOL_LSB   +: COOL_W]   = COOL_W'(cool);
    w[UNLOCK_LSB +: UNLOCK_W] = UNLOCK_W'(unlock);
    return w;
  endfunction

  localparam logic [DATA_W-1:0] PROG0 = pack_prog(1, 8, 2, 4, 2, 6, 1, 1);
  localparam logic [DATA_W-1:0] PROG1 = pack_prog(0, 4, 1, 2, 1, 3, 0, 1);
  localparam logic [DATA_W-1:0] PROG2 = pack_prog(5, 15, 3, 7, 3, 15, 2, 1);
  localparam logic [DATA_W-1:0] PROG3 = pack_prog(0, 0, 0, 0, 1, 9, 1, 1);

  function automatic logic [DATA_W-1:0] prog_word(input logic [1:0] m);
    case (m)
      2'd0:    return PROG0;
      2'd1:    return PROG1;
      2'd2:    return PROG2;
      default: return PROG3;
    endcase
  endfunction

endpackage

// File: rtl/wash_mode_controller_if.sv
// Controller <-> run-timer link: machine state and program word out,
// countdown/finish status back.
interface wash_mode_controller_if;
  import wash_pkg::*;

  logic              had_finish;
  logic [2:0]        init_time;
  logic [2:0]        finish_time;
  logic [2:0]        state;
  logic [DATA_W-1:0] data;

  modport master (input had_finish, init_time, finish_time, output state, data);
  modport slave  (output had_finish, init_time, finish_time, input state, data);
endinterface

// File: rtl/wash_mode_controller_debounce.sv
// Button debouncer: a raw level must differ from the accepted level for
// DEBOUNCE_CYCLES+1 samples; a rising acceptance emits a 1-cycle pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level       <= raw;
        cnt         <= '0;
        press_pulse <= raw;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/wash_mode_controller.sv
// Washing-machine state sequencer: debounced panel buttons drive the
// machine state and selected program word to the run-timer.
module wash_mode_controller
  import wash_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn_power,
  input  logic                          btn_start,
  input  logic                          btn_mode,
  input  logic                          lid_open,
  wash_mode_controller_if.master        timer,
  output logic [1:0]                    mode,
  output logic                          door_lock
);
  localparam int NUM_BTN = 3;

  logic [NUM_BTN-1:0] raw, pulse;
  logic               power_p, start_p, mode_p;

  assign raw = {btn_mode, btn_start, btn_power};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw         (raw[g]),
      .press_pulse (pulse[g])
    );
  end

  assign {mode_p, start_p, power_p} = pulse;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] data_q;
  logic              to_shutdown;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    to_shutdown = 1'b0;
    if (state_q == ST_SHUTDOWN) begin
      if (power_p) state_d = ST_BEGIN;
    end else if (power_p) begin
      state_d     = ST_SHUTDOWN;
      to_shutdown = 1'b1;
    end else begin
      case (state_q)
        ST_BEGIN:  if (timer.init_time == 3'd0) state_d = ST_SET;
        ST_SET: begin
          if (start_p)     state_d = lid_open ? ST_ERROR : ST_RUN;
          else if (mode_p) mode_d  = mode_q + 2'd1;
        end
        ST_RUN: begin
          if (lid_open)              state_d = ST_ERROR;
          else if (timer.had_finish) state_d = ST_FINISH;
          else if (start_p)          state_d = ST_PAUSE;
        end
        ST_PAUSE:  if (start_p) state_d = lid_open ? ST_ERROR : ST_RUN;
        ST_ERROR:  if (start_p && !lid_open) state_d = ST_PAUSE;
        ST_FINISH: begin
          if (timer.finish_time == 3'd0) begin
            state_d     = ST_SHUTDOWN;
            to_shutdown = 1'b1;
          end
        end
        default: begin
          state_d     = ST_SHUTDOWN;
          to_shutdown = 1'b1;
        end
      endcase
    end
  end

  // Program word follows mode one clock later, and only while in SET.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SHUTDOWN;
      mode_q  <= 2'd0;
      data_q  <= PROG0;
    end else begin
      state_q <= state_d;
      if (to_shutdown) begin
        mode_q <= 2'd0;
        data_q <= PROG0;
      end else begin
        mode_q <= mode_d;
        if (state_q == ST_SET) data_q <= prog_word(mode_q);
      end
    end
  end

  assign timer.state = state_q;
  assign timer.data  = data_q;
  assign mode        = mode_q;
  assign door_lock   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
endmodule

// File: tb/tb_wash_mode_controller.sv
// Bench for wash_mode_controller: table of press/level steps plus
// hand-timed sequences, expectations queued and checked against outputs.
module tb_wash_mode_controller;

  localparam logic [25:0] P0 = 26'h0C28989;
  localparam logic [25:0] P1 = 26'h02144C1;
  localparam logic [25:0] P2 = 26'h2FBEFD1;
  localparam logic [25:0] P3 = 26'h0000649;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_power, btn_start, btn_mode, lid_open;
  logic [1:0] mode;
  logic       door_lock;

  wash_mode_controller_if tif ();

  wash_mode_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_power (btn_power),
    .btn_start (btn_start),
    .btn_mode  (btn_mode),
    .lid_open  (lid_open),
    .timer     (tif),
    .mode      (mode),
    .door_lock (door_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pw, st, mb, lid, hf;
    logic [2:0] it, ft;
    logic [2:0] e_state;
    logic [1:0] e_mode;
    logic [25:0] e_data;
    logic       e_lock;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [1:0]  md;
    logic [25:0] dt;
    logic        lk;
  } exp_t;

  vec_t tbl [17];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic pw, logic st, logic mb, logic lid, logic hf,
                              logic [2:0] it, logic [2:0] ft, logic [2:0] e_state,
                              logic [1:0] e_mode, logic [25:0] e_data, logic e_lock);
    vec_t v;
    v.pw = pw; v.st = st; v.mb = mb; v.lid = lid; v.hf = hf;
    v.it = it; v.ft = ft;
    v.e_state = e_state; v.e_mode = e_mode; v.e_data = e_data; v.e_lock = e_lock;
    return v;
  endfunction

  task automatic expect_out(input logic [2:0] st, input logic [1:0] md,
                            input logic [25:0] dt, input logic lk);
    exp_t e;
    e.st = st; e.md = md; e.dt = dt; e.lk = lk;
    sb.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: no expectation queued", name);
    end else begin
      e = sb.pop_front();
      if (tif.state !== e.st || mode !== e.md || tif.data !== e.dt || door_lock !== e.lk) begin
        errors++;
        $display("FAIL %s: got state=%0d mode=%0d data=%h lock=%b, want state=%0d mode=%0d data=%h lock=%b",
                 name, tif.state, mode, tif.data, door_lock, e.st, e.md, e.dt, e.lk);
      end
    end
  endtask

  task automatic run_row(input int i);
    vec_t v;
    v = tbl[i];
    @(negedge clk);
    lid_open = v.lid; tif.had_finish = v.hf;
    tif.init_time = v.it; tif.finish_time = v.ft;
    expect_out(v.e_state, v.e_mode, v.e_data, v.e_lock);
    if (v.pw || v.st || v.mb) begin
      btn_power = v.pw; btn_start = v.st; btn_mode = v.mb;
      repeat (8) @(negedge clk);
      btn_power = 1'b0; btn_start = 1'b0; btn_mode = 1'b0;
      repeat (8) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
    check($sformatf("row%0d", i));
  endtask

  initial begin
    //               pw st mb lid hf it ft  state mode data lock
    tbl[0]  = mk(0, 0, 1, 0, 0, 0, 3, 3'd2, 2'd1, P1, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 3, 3'd2, 2'd2, P2, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0, 3, 3'd2, 2'd3, P3, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 3, 3'd2, 2'd0, P0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 3, 3'd2, 2'd1, P1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 3, 3'd3, 2'd1, P1, 1);
    tbl[6]  = mk(0, 0, 1, 0, 0, 0, 3, 3'd3, 2'd1, P1, 1);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0, 3, 3'd4, 2'd1, P1, 0);
    tbl[8]  = mk(0, 1, 0, 1, 0, 0, 3, 3'd4, 2'd1, P1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 3, 3'd5, 2'd1, P1, 1);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 3, 3'd3, 2'd1, P1, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 3, 3, 3'd1, 2'd0, P0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 3, 3'd2, 2'd0, P0, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 0, 3, 3'd2, 2'd1, P1, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 3, 3'd0, 2'd0, P0, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 3, 3'd2, 2'd0, P0, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 3, 3'd3, 2'd0, P0, 1);

    rst_n = 1'b0;
    btn_power = 1'b0; btn_start = 1'b0; btn_mode = 1'b0; lid_open = 1'b0;
    tif.had_finish = 1'b0; tif.init_time = 3'd5; tif.finish_time = 3'd3;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_out(3'd0, 2'd0, P0, 1'b0);
    check("reset");

    // Power press: pulse lands 5 clks after the raw edge, state one clk later.
    btn_power = 1'b1;
    repeat (5) @(negedge clk);
    expect_out(3'd0, 2'd0, P0, 1'b0);
    check("power_early");
    @(negedge clk);
    expect_out(3'd1, 2'd0, P0, 1'b0);
    check("power_latency");
    btn_power = 1'b0;
    repeat (8) @(negedge clk);

    for (int v = 5; v >= 1; v--) begin
      tif.init_time = 3'(v);
      @(negedge clk);
      expect_out(3'd1, 2'd0, P0, 1'b0);
      check($sformatf("begin_it%0d", v));
    end
    tif.init_time = 3'd0;
    @(negedge clk);
    expect_out(3'd2, 2'd0, P0, 1'b0);
    check("begin_exit");

    for (int i = 0; i <= 10; i++) run_row(i);

    // Start pulse and had_finish in the same cycle: finish wins.
    @(negedge clk);
    btn_start = 1'b1;
    repeat (5) @(negedge clk);
    tif.had_finish = 1'b1;
    @(negedge clk);
    expect_out(3'd6, 2'd1, P1, 1'b0);
    check("finish_over_start");
    btn_start = 1'b0; tif.had_finish = 1'b0;
    repeat (8) @(negedge clk);
    for (int v = 2; v >= 1; v--) begin
      tif.finish_time = 3'(v);
      @(negedge clk);
      expect_out(3'd6, 2'd1, P1, 1'b0);
      check($sformatf("finish_ft%0d", v));
    end
    tif.finish_time = 3'd0;
    @(negedge clk);
    expect_out(3'd0, 2'd0, P0, 1'b0);
    check("finish_exit");
    tif.finish_time = 3'd3;

    // Glitch shorter than the debounce window.
    btn_power = 1'b1;
    repeat (3) @(negedge clk);
    btn_power = 1'b0;
    repeat (10) @(negedge clk);
    expect_out(3'd0, 2'd0, P0, 1'b0);
    check("glitch");

    for (int i = 11; i <= 16; i++) run_row(i);

    // Async reset in RUN, checked before the next rising edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_out(3'd0, 2'd0, P0, 1'b0);
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
